// File: rtl/cpu_wb_cla_mul.sv
// Unsigned array multiplier for the write-back stage: partial products summed through a chain of
// two-level carry-lookahead adders, with the full product registered once.

module cpu_wb_cla_add #(
  parameter int W = 33,
  parameter int G = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NG = (W + G - 1) / G;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   gc;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    // Group generate/propagate; the top group is simply narrower when W is not a multiple of G.
    for (gi = 0; gi < NG; gi++) begin : g_grp
      localparam int LO = gi * G;
      localparam int HI = (LO + G > W) ? W - 1 : LO + G - 1;
      logic gg_v;
      logic gp_v;
      always_comb begin
        logic term;
        gp_v = 1'b1;
        gg_v = 1'b0;
        for (int i = LO; i <= HI; i++) begin
          gp_v = gp_v & p[i];
          term = g[i];
          for (int m = i + 1; m <= HI; m++) term = term & p[m];
          gg_v = gg_v | term;
        end
      end
      assign gg[gi] = gg_v;
      assign gp[gi] = gp_v;
    end

    // Second lookahead level: every group carry is a flat sum of products over lower groups.
    assign gc[0] = 1'b0;
    for (gi = 1; gi <= NG; gi++) begin : g_gcarry
      logic gc_v;
      always_comb begin
        logic term;
        gc_v = 1'b0;
        for (int m = 0; m < gi; m++) begin
          term = gg[m];
          for (int q = m + 1; q < gi; q++) term = term & gp[q];
          gc_v = gc_v | term;
        end
      end
      assign gc[gi] = gc_v;
    end

    // In-group carries expanded from the group carry-in, no bit-to-bit ripple.
    for (gi = 0; gi < W; gi++) begin : g_bit
      localparam int LO = (gi / G) * G;
      logic c_bit;
      always_comb begin
        logic term;
        term = gc[gi / G];
        for (int m = LO; m < gi; m++) term = term & p[m];
        c_bit = term;
        for (int j = LO; j < gi; j++) begin
          term = g[j];
          for (int m = j + 1; m < gi; m++) term = term & p[m];
          c_bit = c_bit | term;
        end
      end
      assign c[gi] = c_bit;
    end
  endgenerate

  assign sum  = p ^ c;
  assign cout = gc[NG];
endmodule

module cpu_wb_cla_mul #(
  parameter int MULTICAND_WID  = 32,
  parameter int MULTIPLIER_WID = 32,
  parameter int CLA_GROUP      = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [MULTICAND_WID-1:0]                multicand,
  input  logic [MULTIPLIER_WID-1:0]               multiplier,
  output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] product
);
  localparam int MC = MULTICAND_WID;
  localparam int MP = MULTIPLIER_WID;

  logic [MC+MP-1:0] product_next;
  logic             unused_cout;

  genvar gi;
  generate
    // Each stage adds its partial product to the running sum shifted right by one; the LSB retires.
    for (gi = 0; gi < MP; gi++) begin : g_stage
      logic [MC:0] acc;
      logic        co;
      if (gi == 0) begin : g_first
        assign acc = {1'b0, multicand & {MC{multiplier[0]}}};
        assign co  = 1'b0;
      end else begin : g_add
        cpu_wb_cla_add #(.W(MC + 1), .G(CLA_GROUP)) u_add (
          .a    ({g_stage[gi-1].co, g_stage[gi-1].acc[MC:1]}),
          .b    ({1'b0, multicand & {MC{multiplier[gi]}}}),
          .sum  (acc),
          .cout (co)
        );
      end
      assign product_next[gi] = acc[0];
    end
  endgenerate

  assign product_next[MC+MP-1:MP] = g_stage[MP-1].acc[MC:1];
  // The final carry-out can never be set because the product always fits.
  assign unused_cout = g_stage[MP-1].co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) product <= '0;
    else        product <= product_next;
  end
endmodule

// File: tb/tb_cpu_wb_cla_mul.sv
// Directed and randomised checks of the registered CLA multiplier against hand-computed products.
`timescale 1ns/1ps

module tb_cpu_wb_cla_mul;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] multicand = '0;
  logic [31:0] multiplier = '0;
  logic [63:0] product;

  int n_checks = 0;
  int n_fail = 0;

  cpu_wb_cla_mul #(.MULTICAND_WID(32), .MULTIPLIER_WID(32), .CLA_GROUP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .multicand  (multicand),
    .multiplier (multiplier),
    .product    (product)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, actual);
    end
  endtask

  // Present operands before an edge, then look one step after it.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expected);
    @(negedge clk);
    multicand  = a;
    multiplier = b;
    @(posedge clk);
    #1;
    check_eq(tag, product, expected);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_q;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset held with non-zero operands and a running clock.
    multicand  = 32'hFFFF;
    multiplier = 32'hFF;
    #1;
    check_eq("reset_t0", product, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_hold", product, 64'h0);
    end
    rst_n = 1'b1;
    #1;
    check_eq("release_no_edge", product, 64'h0);
    @(posedge clk);
    #1;
    check_eq("release_first", product, 64'hFEFF01);

    // Ramp n*n for n = 0..30.
    for (int n = 0; n <= 30; n++) begin
      apply($sformatf("ramp_%0d", n), 32'(n), 32'(n), 64'(n * n));
    end
    check_eq("ramp_last", product, 64'h384);

    // Operand changes between edges must not reach product.
    @(negedge clk);
    multicand  = 32'h1234;
    multiplier = 32'h5678;
    #2;
    check_eq("no_edge_change", product, 64'h384);

    apply("cc_7fff_7f", 32'h7FFF, 32'h7F, 64'h3F7F81);
    apply("cc_8000_f0", 32'h8000, 32'hF0, 64'h780000);
    apply("cc_8ff0_f0", 32'h8FF0, 32'hF0, 64'h86F100);
    apply("cc_7ff0_f7", 32'h7FF0, 32'hF7, 64'h7B7090);
    apply("cc_ffff_ff", 32'hFFFF, 32'hFF, 64'hFEFF01);

    apply("max_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    apply("msb_x2",    32'h80000000, 32'h2,        64'h100000000);
    apply("zero_x",    32'h0,        32'hFFFFFFFF, 64'h0);
    apply("one_x",     32'h1,        32'hDEADBEEF, 64'hDEADBEEF);
    apply("x_one",     32'hCAFEF00D, 32'h1,        64'hCAFEF00D);

    // Mid-stream asynchronous reset between edges.
    apply("stream_a", 32'h1234, 32'h10, 64'h12340);
    @(negedge clk);
    multicand  = 32'h100;
    multiplier = 32'h100;
    rst_n = 1'b0;
    #1;
    check_eq("midreset_async", product, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midreset_after", product, 64'h10000);

    // Random pairs with occasional reset pulses between edges.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra = $urandom;
      rb = $urandom;
      multicand  = ra;
      multiplier = rb;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        check_eq("rand_reset", product, 64'h0);
        rst_n = 1'b1;
      end
      exp_q = 64'(ra) * 64'(rb);
      @(posedge clk);
      #1;
      check_eq($sformatf("rand_%0d", i), product, exp_q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
